// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART byte transmitter between two requesters.
// Round-robin between requester 0 (CPU path) and requester 1 (status reporter).
// Ownership is held for a whole multi-byte frame. Each byte gets one tx_en
// pulse, and the transmitter's busy handshake must finish before the next byte.
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   reqN_valid/data/last  requester N byte offer (last marks end of frame)
//   reqN_ready            byte accepted this cycle (combinational)
//   tx_busy               transmitter is serializing
//   tx_en, UART_TX        one-cycle start pulse and the byte it carries
//   arb_idle              high only in the idle state
//   owner                 current or last grantee
//   locked                a multi-byte frame is in progress
module uart_tx_arbiter #(
  parameter int unsigned BUSY_TIMEOUT  = 16,
  parameter int unsigned FRAME_TIMEOUT = 1024
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] UART_TX,
  output logic       arb_idle,
  output logic       owner,
  output logic       locked
);

  localparam int unsigned BusyW  = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned FrameW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [BusyW-1:0]  BusyLim  = BusyW'(BUSY_TIMEOUT);
  localparam logic [FrameW-1:0] FrameLim = FrameW'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLock,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e            r_state, w_state_d;
  logic [7:0]        r_tx_data, w_tx_data_d;
  logic              r_tx_last, w_tx_last_d;
  logic              r_owner, w_owner_d;
  logic              r_last_grant, w_last_grant_d;
  logic              r_locked, w_locked_d;
  logic [BusyW-1:0]  r_busy_cnt, w_busy_cnt_d;
  logic [FrameW-1:0] r_frame_cnt, w_frame_cnt_d;

  logic w_grant0, w_grant1, w_post;

  // Grant selection: only the idle/lock states may accept a byte.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == StIdle) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end else if (r_state == StLock) begin
      w_grant0 = ~r_owner & req0_valid;
      w_grant1 = r_owner & req1_valid;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_tx_data_d    = r_tx_data;
    w_tx_last_d    = r_tx_last;
    w_owner_d      = r_owner;
    w_last_grant_d = r_last_grant;
    w_locked_d     = r_locked;
    w_busy_cnt_d   = r_busy_cnt;
    w_frame_cnt_d  = r_frame_cnt;
    w_post         = 1'b0;

    unique case (r_state)
      StIdle, StLock: begin
        if (w_grant0 || w_grant1) begin
          w_tx_data_d    = w_grant1 ? req1_data : req0_data;
          w_tx_last_d    = w_grant1 ? req1_last : req0_last;
          w_owner_d      = w_grant1;
          w_last_grant_d = w_grant1;
          w_frame_cnt_d  = '0;
          w_state_d      = StIssue;
        end else if (r_state == StLock) begin
          // Owner stalled mid-frame: release the lock after the idle budget.
          if (r_frame_cnt >= FrameLim) begin
            w_locked_d = 1'b0;
            w_state_d  = StIdle;
          end else begin
            w_frame_cnt_d = r_frame_cnt + 1'b1;
          end
        end
      end
      StIssue: begin
        w_busy_cnt_d = '0;
        w_state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          w_state_d = StWaitDone;
        end else if (r_busy_cnt >= BusyLim) begin
          // Transmitter never acknowledged; treat the byte as sent.
          w_post = 1'b1;
        end else begin
          w_busy_cnt_d = r_busy_cnt + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          w_post = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_post) begin
      w_locked_d = ~r_tx_last;
      w_state_d  = r_tx_last ? StIdle : StLock;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= StIdle;
      r_tx_data    <= '0;
      r_tx_last    <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_locked     <= 1'b0;
      r_busy_cnt   <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_tx_data    <= w_tx_data_d;
      r_tx_last    <= w_tx_last_d;
      r_owner      <= w_owner_d;
      r_last_grant <= w_last_grant_d;
      r_locked     <= w_locked_d;
      r_busy_cnt   <= w_busy_cnt_d;
      r_frame_cnt  <= w_frame_cnt_d;
    end
  end

  // Readies are gated by reset so they drop the instant reset asserts.
  assign req0_ready = w_grant0 & HRESETn;
  assign req1_ready = w_grant1 & HRESETn;
  assign tx_en      = (r_state == StIssue);
  assign UART_TX    = (r_state == StIssue) ? r_tx_data : 8'h00;
  assign arb_idle   = (r_state == StIdle);
  assign owner      = r_owner;
  assign locked     = r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level reference model checked against the DUT every cycle.
module tb_uart_tx_arbiter;

  localparam int BT = 16;
  localparam int FT = 1024;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       tx_busy, tx_en, arb_idle, owner, locked;
  logic [7:0] UART_TX;

  uart_tx_arbiter #(
    .BUSY_TIMEOUT (BT),
    .FRAME_TIMEOUT(FT)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_last (req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_last (req1_last),
    .req1_ready(req1_ready),
    .tx_busy   (tx_busy),
    .tx_en     (tx_en),
    .UART_TX   (UART_TX),
    .arb_idle  (arb_idle),
    .owner     (owner),
    .locked    (locked)
  );

  always #5 HCLK = ~HCLK;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Requester byte queues: {last, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit go0 = 0, go1 = 0;

  // Transmitter emulation controls
  bit tx_rand  = 0;
  bit tx_stuck = 0;
  int tx_len   = 1;

  // Log of issued bytes as observed on the DUT
  int log_b[$];
  int log_t[$];
  int log_l[$];
  int r0_hi = 0;
  int acc_t0 = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] lb(input int i);
    if (i < log_b.size()) return 32'(log_b[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] ll(input int i);
    if (i < log_l.size()) return 32'(log_l[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] gap(input int i);
    if (i + 1 < log_t.size()) return 32'(log_t[i+1] - log_t[i]);
    return 'x;
  endfunction

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // Requester drivers: present queue head, pop after an accepted cycle.
  initial begin
    bit acc;
    req0_valid = 0; req0_data = 0; req0_last = 0;
    forever begin
      @(negedge HCLK);
      acc = req0_valid && req0_ready;
      @(posedge HCLK);
      #1;
      if (acc && q0.size() > 0) void'(q0.pop_front());
      if (go0 && q0.size() > 0) begin
        req0_valid = 1'b1;
        {req0_last, req0_data} = q0[0];
      end else begin
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
      end
    end
  end

  initial begin
    bit acc;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    forever begin
      @(negedge HCLK);
      acc = req1_valid && req1_ready;
      @(posedge HCLK);
      #1;
      if (acc && q1.size() > 0) void'(q1.pop_front());
      if (go1 && q1.size() > 0) begin
        req1_valid = 1'b1;
        {req1_last, req1_data} = q1[0];
      end else begin
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      end
    end
  end

  // Transmitter: after each tx_en, raise busy after d cycles for l cycles.
  initial begin
    int d, l;
    tx_busy = 1'b0;
    forever begin
      @(negedge HCLK);
      if (tx_en === 1'b1 && HRESETn && !tx_stuck) begin
        if (tx_rand) begin
          d = ($urandom_range(0, 9) == 0) ? BT + 1 : int'($urandom_range(0, 2));
          l = $urandom_range(1, 4);
        end else begin
          d = 0;
          l = tx_len;
        end
        repeat (d + 1) @(posedge HCLK);
        #1 tx_busy = 1'b1;
        repeat (l) @(posedge HCLK);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Reference model: transaction view of the arbiter.
  //   m_free  : a new byte may be accepted this cycle
  //   m_issue : an accepted byte goes out this cycle
  //   m_phase : 1 = awaiting busy rise (m_wcnt cycles so far), 2 = awaiting fall
  initial begin
    bit m_free, m_lock, m_owner, m_lg, m_issue, m_blast;
    int m_byte, m_phase, m_wcnt, m_idle;
    bit e_r0, e_r1, done;
    m_free = 1; m_lock = 0; m_owner = 0; m_lg = 1; m_issue = 0; m_blast = 0;
    m_byte = 0; m_phase = 0; m_wcnt = 0; m_idle = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        m_free = 1; m_lock = 0; m_owner = 0; m_lg = 1; m_issue = 0; m_blast = 0;
        m_byte = 0; m_phase = 0; m_wcnt = 0; m_idle = 0;
      end
      e_r0 = 0;
      e_r1 = 0;
      if (HRESETn && m_free) begin
        if (m_lock) begin
          if (m_owner) e_r1 = req1_valid;
          else         e_r0 = req0_valid;
        end else if (req0_valid && req1_valid) begin
          e_r0 = m_lg;
          e_r1 = !m_lg;
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("tx_en", 32'(tx_en), 32'(m_issue));
      chk("UART_TX", 32'(UART_TX), m_issue ? 32'(m_byte) : 32'd0);
      chk("arb_idle", 32'(arb_idle), 32'(m_free && !m_lock));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("locked", 32'(locked), 32'(m_lock));

      if (tx_en === 1'b1) begin
        log_b.push_back(int'(UART_TX));
        log_t.push_back(cyc);
        log_l.push_back(int'(locked));
      end
      if (req0_ready === 1'b1) begin
        r0_hi++;
        acc_t0 = cyc;
      end

      if (HRESETn) begin
        done = 0;
        if (e_r0 || e_r1) begin
          m_free  = 0;
          m_issue = 1;
          m_byte  = e_r1 ? int'(req1_data) : int'(req0_data);
          m_blast = e_r1 ? req1_last : req0_last;
          m_owner = e_r1;
          m_lg    = e_r1;
          m_idle  = 0;
        end else if (m_free && m_lock) begin
          m_idle++;
          if (m_idle >= FT) m_lock = 0;
        end else if (m_issue) begin
          m_issue = 0;
          m_phase = 1;
          m_wcnt  = 0;
        end else if (m_phase == 1) begin
          if (tx_busy) m_phase = 2;
          else if (m_wcnt == BT) done = 1;
          else m_wcnt++;
        end else if (m_phase == 2 && !tx_busy) begin
          done = 1;
        end
        if (done) begin
          m_phase = 0;
          m_free  = 1;
          m_lock  = !m_blast;
        end
      end
    end
  end

  task automatic clear_log();
    log_b.delete(); log_t.delete(); log_l.delete();
    r0_hi = 0; acc_t0 = -1;
  endtask

  task automatic wait_busy_low();
    int k = 0;
    while (tx_busy && k < 50) begin
      @(posedge HCLK); k++;
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge HCLK);
    #1 HRESETn = 1'b0;
    go0 = 0; go1 = 0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    wait_busy_low();
    @(negedge HCLK);
    clear_log();
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    int k = 0;
    while (log_b.size() < n && k < budget) begin
      @(posedge HCLK); k++;
    end
    if (log_b.size() < n) chk({name, "_timeout"}, 32'(log_b.size()), 32'(n));
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int k = 0;
    while (!(arb_idle && !tx_busy && q0.size() == 0 && q1.size() == 0 &&
             !req0_valid && !req1_valid) && k < budget) begin
      @(posedge HCLK); k++;
    end
    if (k >= budget) chk({name, "_quiet_timeout"}, 32'(k), 32'(0));
    @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_arb_idle", 32'(arb_idle), 32'd1);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_uart_tx", 32'(UART_TX), 32'd0);

    // Single byte
    clear_log();
    #1 q0.push_back({1'b1, 8'h41}); go0 = 1;
    wait_log("single", 1, 50);
    wait_quiet("single", 100);
    chk("single_byte", lb(0), 32'h41);
    chk("single_ready_cycles", 32'(r0_hi), 32'd1);
    chk("single_latency", 32'(log_t.size() > 0 ? log_t[0] - acc_t0 : -1), 32'd1);
    chk("single_arb_idle", 32'(arb_idle), 32'd1);
    chk("single_locked", 32'(locked), 32'd0);

    // Tie and fairness
    do_reset();
    #1 q0.push_back({1'b1, 8'hA0}); q1.push_back({1'b1, 8'hB0}); go0 = 1; go1 = 1;
    wait_log("tie", 2, 100);
    wait_quiet("tie", 100);
    #1 q0.push_back({1'b1, 8'hA1}); q1.push_back({1'b1, 8'hB1});
    wait_log("tie2", 4, 100);
    wait_quiet("tie2", 100);
    chk("tie_first", lb(0), 32'hA0);
    chk("tie_second", lb(1), 32'hB0);
    chk("tie2_first", lb(2), 32'hA1);
    chk("tie2_second", lb(3), 32'hB1);

    // Frame lock: req1 starts the frame, req0 waits throughout
    do_reset();
    #1 q1.push_back({1'b0, 8'h10}); q1.push_back({1'b0, 8'h11}); q1.push_back({1'b1, 8'h12});
    go1 = 1;
    wait_log("frame", 1, 50);
    @(negedge HCLK);
    #1 q0.push_back({1'b1, 8'h55}); go0 = 1;
    wait_log("frame", 4, 200);
    wait_quiet("frame", 100);
    chk("frame_b0", lb(0), 32'h10);
    chk("frame_b1", lb(1), 32'h11);
    chk("frame_b2", lb(2), 32'h12);
    chk("frame_b3", lb(3), 32'h55);
    chk("frame_lock0", ll(0), 32'd0);
    chk("frame_lock1", ll(1), 32'd1);
    chk("frame_lock2", ll(2), 32'd1);
    chk("frame_lock3", ll(3), 32'd0);

    // Frame timeout: req0 stalls after a non-last byte
    do_reset();
    #1 q0.push_back({1'b0, 8'h01}); q1.push_back({1'b1, 8'h77}); go0 = 1; go1 = 1;
    wait_log("ftmo", 2, FT + 200);
    wait_quiet("ftmo", 100);
    chk("ftmo_b0", lb(0), 32'h01);
    chk("ftmo_b1", lb(1), 32'h77);
    chk("ftmo_gap", gap(0), 32'(FT + 4));

    // Busy timeout: transmitter never raises busy
    do_reset();
    #1 tx_stuck = 1;
    q0.push_back({1'b1, 8'hC1}); q0.push_back({1'b1, 8'hC2}); go0 = 1;
    wait_log("btmo", 2, 4 * BT + 50);
    wait_quiet("btmo", 4 * BT);
    chk("btmo_b0", lb(0), 32'hC1);
    chk("btmo_b1", lb(1), 32'hC2);
    chk("btmo_gap", gap(0), 32'(BT + 3));
    #1 tx_stuck = 0;

    // Reset during WAIT_DONE
    do_reset();
    #1 tx_len = 3;
    q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21}); go1 = 1;
    wait_log("mid", 1, 50);
    @(posedge HCLK);
    #2;
    chk("mid_owner_pre", 32'(owner), 32'd1);
    HRESETn = 1'b0;
    #1;
    chk("mid_tx_en", 32'(tx_en), 32'd0);
    chk("mid_uart_tx", 32'(UART_TX), 32'd0);
    chk("mid_ready0", 32'(req0_ready), 32'd0);
    chk("mid_ready1", 32'(req1_ready), 32'd0);
    chk("mid_arb_idle", 32'(arb_idle), 32'd1);
    chk("mid_owner", 32'(owner), 32'd0);
    chk("mid_locked", 32'(locked), 32'd0);
    @(negedge HCLK);
    #1 go0 = 0; go1 = 0; q0.delete(); q1.delete();
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    tx_len = 1;
    wait_busy_low();
    @(negedge HCLK);
    clear_log();
    #1 q0.push_back({1'b1, 8'h30}); q1.push_back({1'b1, 8'h31}); go0 = 1; go1 = 1;
    wait_log("post_rst", 2, 100);
    wait_quiet("post_rst", 100);
    chk("post_rst_first", lb(0), 32'h30);
    chk("post_rst_second", lb(1), 32'h31);

    // Randomized traffic, including stalls and late/missing busy
    do_reset();
    #1 tx_rand = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge HCLK);
      #1;
      if ($urandom_range(0, 3) == 0 && q0.size() < 4)
        q0.push_back({1'($urandom_range(0, 2) != 0), 8'($urandom)});
      if ($urandom_range(0, 3) == 0 && q1.size() < 4)
        q1.push_back({1'($urandom_range(0, 2) != 0), 8'($urandom)});
      go0 = ($urandom_range(0, 7) != 0);
      go1 = ($urandom_range(0, 7) != 0);
    end
    go0 = 1; go1 = 1;
    wait_quiet("random", 20000);
    chk("random_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
